// File: rtl/generic_fifo_lvl.sv
// Valid/grant FIFO of any depth, with fill level, almost-full/almost-empty flags, flush and optional fall-through.
// Latency: 1 cycle from push to data_o; 0 cycles when FALL_THROUGH=1 and the FIFO is empty.
// Backpressure: grant_o drops when full or during flush; valid_o holds the head until grant_i.
module generic_fifo_lvl #(
  parameter int DATA_WIDTH   = 32,
  parameter int DATA_DEPTH   = 8,
  parameter int FALL_THROUGH = 0,
  parameter int AF_THRESH    = 6,
  parameter int AE_THRESH    = 1,
  localparam int LW          = $clog2(DATA_DEPTH + 1),
  localparam int PW          = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  test_mode_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  grant_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  grant_i,
  output logic [LW-1:0]         level_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
);

  typedef enum logic [1:0] {EMPTY, MIDDLE, FULL} state_t;

  state_t                state;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LW-1:0]         level;
  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  logic ft_empty;
  logic push;
  logic pop;
  logic bypass;
  logic wr_en;
  logic rd_en;
  logic store_clk_en;

  // Pointers wrap explicitly at DATA_DEPTH-1 so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DATA_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake outputs decoded from state; flush masks both sides of the handshake.
  always_comb begin
    ft_empty     = (FALL_THROUGH != 0) && (state == EMPTY);
    grant_o      = !flush_i && (state != FULL);
    valid_o      = !flush_i && ((state != EMPTY) || (ft_empty && valid_i));
    data_o       = ft_empty ? data_i : mem[rd_ptr];
    push         = valid_i && grant_o;
    pop          = valid_o && grant_i;
    // An empty fall-through FIFO hands the word straight across without storing it.
    bypass       = ft_empty && push && pop;
    wr_en        = push && !bypass;
    rd_en        = pop && !bypass;
    // Storage enable is the gating term: open only on a real write, or always in test mode.
    store_clk_en = wr_en || test_mode_i;
  end

  // Control state, pointers and level on the free-running clock; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      state  <= EMPTY;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      case (state)
        EMPTY:  if (wr_en) state <= MIDDLE;
        MIDDLE: begin
          if (wr_en && !rd_en && level == LW'(DATA_DEPTH - 1))
            state <= FULL;
          else if (rd_en && !wr_en && level == LW'(1))
            state <= EMPTY;
        end
        FULL:   if (rd_en) state <= MIDDLE;
        default: state <= EMPTY;
      endcase
    end
  end

  // Storage array; contents survive flush and are only cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DATA_DEPTH; i++) mem[i] <= '0;
    end else if (store_clk_en) begin
      if (wr_en) mem[wr_ptr] <= data_i;
    end
  end

  // Level-derived outputs.
  always_comb begin
    level_o        = level;
    almost_full_o  = (32'(level) >= AF_THRESH);
    almost_empty_o = (32'(level) <= AE_THRESH);
  end

endmodule
